// File: rtl/jtag_dmi_pkg.sv
// rtl/jtag_dmi_pkg.sv - shared codes, states and field offsets for the JTAG DMI transport
package jtag_dmi_pkg;

  localparam logic [4:0] IR_BYPASS0   = 5'h00;
  localparam logic [4:0] IR_IDCODE    = 5'h01;
  localparam logic [4:0] IR_DTMCS     = 5'h10;
  localparam logic [4:0] IR_DMIACCESS = 5'h11;
  localparam logic [4:0] IR_BYPASS1   = 5'h1f;

  localparam int DTMCS_VERSION      = 0;
  localparam int DTMCS_ABITS        = 4;
  localparam int DTMCS_DMISTAT      = 10;
  localparam int DTMCS_IDLE         = 12;
  localparam int DTMCS_DMIRESET     = 16;
  localparam int DTMCS_DMIHARDRESET = 17;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_e;

  typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE, OP_READ_INC} dmi_op_e;
  typedef enum logic [1:0] {STAT_OK, STAT_RSVD, STAT_FAILED, STAT_BUSY} dmi_stat_e;
  typedef enum logic [1:0] {ENG_IDLE, ENG_REQ, ENG_RSP} eng_state_e;
  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - IEEE 1149.1 TAP state machine with one-hot IR/DR strobes
module jtag_tap_fsm
  import jtag_dmi_pkg::*;
(
  input  logic tck_i,
  input  logic trst_,
  input  logic tms_i,
  output logic test_logic_reset,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir
);

  tap_state_e state, state_next;

  always_ff @(posedge tck_i or posedge trst_) begin
    if (trst_) state <= TEST_LOGIC_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms_i ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        state_next = tms_i ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms_i ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         state_next = tms_i ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         state_next = tms_i ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_next = tms_i ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         state_next = tms_i ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        state_next = tms_i ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        state_next = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms_i ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         state_next = tms_i ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         state_next = tms_i ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_next = tms_i ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         state_next = tms_i ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_next = tms_i ? SELECT_DR : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    test_logic_reset = 1'b0;
    capture_dr       = 1'b0;
    shift_dr         = 1'b0;
    update_dr        = 1'b0;
    capture_ir       = 1'b0;
    shift_ir         = 1'b0;
    update_ir        = 1'b0;
    case (state)
      TEST_LOGIC_RESET: test_logic_reset = 1'b1;
      CAPTURE_DR:       capture_dr       = 1'b1;
      SHIFT_DR:         shift_dr         = 1'b1;
      UPDATE_DR:        update_dr        = 1'b1;
      CAPTURE_IR:       capture_ir       = 1'b1;
      SHIFT_IR:         shift_ir         = 1'b1;
      UPDATE_IR:        update_ir        = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/jtag_dmi_tap.sv
// rtl/jtag_dmi_tap.sv - JTAG TAP with IDCODE/BYPASS/DTMCS/DMIACCESS and a DMI request engine
module jtag_dmi_tap
  import jtag_dmi_pkg::*;
#(
  parameter int          IR_LENGTH    = 5,
  parameter int          AW           = 17,
  parameter int          DW           = 32,
  parameter logic [31:0] IDCODE_VALUE = 32'hdeadbeef
) (
  input  logic          tck_i,
  input  logic          trst_,
  input  logic          tms_i,
  input  logic          td_i,
  output logic          td_o,
  output logic          tdo_oe_o,
  output logic          req_valid_o,
  input  logic          req_ready_i,
  output logic          req_write_o,
  output logic [AW-1:0] req_addr_o,
  output logic [DW-1:0] req_data_o,
  input  logic          rsp_valid_i,
  output logic          rsp_ready_o,
  input  logic [DW-1:0] rsp_data_i,
  input  logic          rsp_err_i
);

  localparam int DMI_W = AW + DW + 2;
  localparam int DR_W  = (DMI_W > 32) ? DMI_W : 32;

  logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_tap_fsm (
    .tck_i            (tck_i),
    .trst_            (trst_),
    .tms_i            (tms_i),
    .test_logic_reset (tlr),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir)
  );

  logic [IR_LENGTH-1:0] ir, ir_shift;
  logic [DR_W-1:0]      dr, dr_shifted, dr_capture;
  dr_sel_e              dr_sel;
  logic [31:0]          dtmcs_rd;

  eng_state_e           eng_state, eng_next;
  dmi_stat_e            sticky, cap_stat;
  logic [AW-1:0]        last_addr;
  logic [DW-1:0]        last_rdata;
  logic                 post_inc;

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir == IR_LENGTH'(IR_IDCODE))         dr_sel = DR_IDCODE;
    else if (ir == IR_LENGTH'(IR_DTMCS))     dr_sel = DR_DTMCS;
    else if (ir == IR_LENGTH'(IR_DMIACCESS)) dr_sel = DR_DMI;
  end

  always_ff @(posedge tck_i or posedge trst_) begin
    if (trst_) begin
      ir       <= IR_LENGTH'(IR_IDCODE);
      ir_shift <= '0;
    end else begin
      if (capture_ir)    ir_shift <= IR_LENGTH'(1);
      else if (shift_ir) ir_shift <= {td_i, ir_shift[IR_LENGTH-1:1]};
      if (tlr)            ir <= IR_LENGTH'(IR_IDCODE);
      else if (update_ir) ir <= ir_shift;
    end
  end

  // A busy engine is reported on capture without being recorded as sticky.
  assign cap_stat = (eng_state != ENG_IDLE) ? STAT_BUSY : sticky;

  always_comb begin
    dtmcs_rd = '0;
    dtmcs_rd[DTMCS_VERSION +: 4] = 4'd1;
    dtmcs_rd[DTMCS_ABITS +: 6]   = 6'(AW);
    dtmcs_rd[DTMCS_DMISTAT +: 2] = sticky;
    dtmcs_rd[DTMCS_IDLE +: 3]    = 3'd1;
  end

  always_comb begin
    dr_capture = '0;
    case (dr_sel)
      DR_IDCODE: dr_capture = DR_W'(IDCODE_VALUE | 32'd1);
      DR_DTMCS:  dr_capture = DR_W'(dtmcs_rd);
      DR_DMI:    dr_capture = DR_W'({last_addr, last_rdata, cap_stat});
      default:   dr_capture = '0;
    endcase
  end

  // Each register shifts in at its own MSB so bit 0 always leads on td_o.
  always_comb begin
    dr_shifted = dr >> 1;
    case (dr_sel)
      DR_BYPASS: dr_shifted[0]       = td_i;
      DR_DMI:    dr_shifted[DMI_W-1] = td_i;
      default:   dr_shifted[31]      = td_i;
    endcase
  end

  always_ff @(posedge tck_i or posedge trst_) begin
    if (trst_)           dr <= '0;
    else if (capture_dr) dr <= dr_capture;
    else if (shift_dr)   dr <= dr_shifted;
  end

  always_ff @(negedge tck_i or posedge trst_) begin
    if (trst_) begin
      td_o     <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_oe_o <= shift_ir | shift_dr;
      td_o     <= shift_ir ? ir_shift[0] : (shift_dr ? dr[0] : 1'b0);
    end
  end

  dmi_op_e       op;
  logic [AW-1:0] dmi_addr;
  logic [DW-1:0] dmi_data;
  logic          dmi_update, dmi_start, dmi_busy_hit;
  logic          dmireset, hardreset, rsp_fire;

  assign op           = dmi_op_e'(dr[1:0]);
  assign dmi_data     = dr[DW+1:2];
  assign dmi_addr     = dr[DMI_W-1:DW+2];
  assign dmi_update   = update_dr && (dr_sel == DR_DMI) && (op != OP_NOP) && (sticky == STAT_OK);
  assign dmi_start    = dmi_update && (eng_state == ENG_IDLE);
  assign dmi_busy_hit = dmi_update && (eng_state != ENG_IDLE);
  assign dmireset     = update_dr && (dr_sel == DR_DTMCS) && dr[DTMCS_DMIRESET];
  assign hardreset    = update_dr && (dr_sel == DR_DTMCS) && dr[DTMCS_DMIHARDRESET];
  assign rsp_fire     = (eng_state == ENG_RSP) && rsp_valid_i && !hardreset && !tlr;

  always_ff @(posedge tck_i or posedge trst_) begin
    if (trst_) eng_state <= ENG_IDLE;
    else       eng_state <= eng_next;
  end

  always_comb begin
    eng_next = eng_state;
    case (eng_state)
      ENG_IDLE: if (dmi_start)   eng_next = ENG_REQ;
      ENG_REQ:  if (req_ready_i) eng_next = ENG_RSP;
      ENG_RSP:  if (rsp_valid_i) eng_next = ENG_IDLE;
      default:                   eng_next = ENG_IDLE;
    endcase
    if (tlr || hardreset) eng_next = ENG_IDLE;
  end

  always_comb begin
    req_valid_o = (eng_state == ENG_REQ);
    rsp_ready_o = (eng_state == ENG_RSP);
  end

  always_ff @(posedge tck_i or posedge trst_) begin
    if (trst_) begin
      req_write_o <= 1'b0;
      req_addr_o  <= '0;
      req_data_o  <= '0;
      last_addr   <= '0;
      last_rdata  <= '0;
      post_inc    <= 1'b0;
      sticky      <= STAT_OK;
    end else begin
      if (dmi_start) begin
        req_write_o <= (op == OP_WRITE);
        req_addr_o  <= dmi_addr;
        req_data_o  <= dmi_data;
        last_addr   <= dmi_addr;
        post_inc    <= (op == OP_READ_INC);
      end
      if (rsp_fire) begin
        if (!req_write_o) last_rdata <= rsp_data_i;
        if (rsp_err_i)    sticky     <= STAT_FAILED;
        if (post_inc)     last_addr  <= req_addr_o + AW'(1);
      end
      if (dmi_busy_hit)                 sticky <= STAT_BUSY;
      if (tlr || dmireset || hardreset) sticky <= STAT_OK;
    end
  end

endmodule

// File: tb/tb_jtag_dmi_tap.sv
// tb/tb_jtag_dmi_tap.sv - directed self-checking bench for jtag_dmi_tap
module tb_jtag_dmi_tap;

  logic        tck_i = 1'b0;
  logic        trst_ = 1'b0;
  logic        tms_i = 1'b1;
  logic        td_i  = 1'b0;
  logic        td_o, tdo_oe_o;
  logic        req_valid_o, req_write_o, rsp_ready_o;
  logic        req_ready_i = 1'b0;
  logic [16:0] req_addr_o;
  logic [31:0] req_data_o;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_data_i  = '0;
  logic        rsp_err_i   = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  jtag_dmi_tap #(
    .IR_LENGTH    (5),
    .AW           (17),
    .DW           (32),
    .IDCODE_VALUE (32'hdeadbeef)
  ) dut (
    .tck_i       (tck_i),
    .trst_       (trst_),
    .tms_i       (tms_i),
    .td_i        (td_i),
    .td_o        (td_o),
    .tdo_oe_o    (tdo_oe_o),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .req_write_o (req_write_o),
    .req_addr_o  (req_addr_o),
    .req_data_o  (req_data_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_data_i  (rsp_data_i),
    .rsp_err_i   (rsp_err_i)
  );

  always #5 tck_i = ~tck_i;

  function automatic logic [63:0] dmi(input logic [16:0] a, input logic [31:0] d, input logic [1:0] op);
    return {13'b0, a, d, op};
  endfunction

  // td_o is sampled while tck is low, before the rising edge that consumes tms/tdi.
  task automatic tck_step(input logic tms, input logic tdi, output logic tdo);
    tms_i = tms;
    td_i  = tdi;
    tdo   = td_o;
    @(posedge tck_i);
    @(negedge tck_i);
    #1;
  endtask

  task automatic scan_ir(input logic [4:0] code, output logic [4:0] cap);
    logic b;
    cap = '0;
    tck_step(1'b1, 1'b0, b);
    tck_step(1'b1, 1'b0, b);
    tck_step(1'b0, 1'b0, b);
    tck_step(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      tck_step(i == 4, code[i], b);
      cap[i] = b;
    end
    tck_step(1'b1, 1'b0, b);
    tck_step(1'b0, 1'b0, b);
  endtask

  task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout, output logic oe_all);
    logic b;
    dout   = '0;
    oe_all = 1'b1;
    tck_step(1'b1, 1'b0, b);
    tck_step(1'b0, 1'b0, b);
    tck_step(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      oe_all = oe_all & tdo_oe_o;
      tck_step(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_step(1'b1, 1'b0, b);
    tck_step(1'b0, 1'b0, b);
  endtask

  // Downstream with zero wait states: ready one edge after the request, response on the next.
  task automatic downstream(input logic [31:0] rdata, input logic err,
                            output logic v, output logic w, output logic [16:0] a,
                            output logic [31:0] d, output logic rr);
    logic b;
    v = req_valid_o;
    w = req_write_o;
    a = req_addr_o;
    d = req_data_o;
    req_ready_i = 1'b1;
    tck_step(1'b0, 1'b0, b);
    req_ready_i = 1'b0;
    rr = rsp_ready_o & ~req_valid_o;
    rsp_valid_i = 1'b1;
    rsp_data_i  = rdata;
    rsp_err_i   = err;
    tck_step(1'b0, 1'b0, b);
    rsp_valid_i = 1'b0;
    rsp_err_i   = 1'b0;
    rr = rr & ~rsp_ready_o;
  endtask

  task automatic test_reset;
    logic [63:0] dout;
    logic [4:0]  cap;
    logic        oe, b;
    #2 trst_ = 1'b1;
    repeat (2) @(posedge tck_i);
    #1;
    tests_run++;
    if ({td_o, tdo_oe_o, req_valid_o, req_write_o, rsp_ready_o, req_addr_o, req_data_o} !== '0) begin
      $display("FAIL reset_outputs: got %h required 0",
               {td_o, tdo_oe_o, req_valid_o, req_write_o, rsp_ready_o, req_addr_o, req_data_o});
      tests_failed++;
    end
    @(negedge tck_i);
    #1 trst_ = 1'b0;
    tck_step(1'b0, 1'b0, b);
    scan_dr(64'h0, 32, dout, oe);
    tests_run++;
    if (dout[31:0] !== 32'hdeadbeef) begin
      $display("FAIL idcode_default: got %h required deadbeef", dout[31:0]);
      tests_failed++;
    end
    tests_run++;
    if (oe !== 1'b1 || tdo_oe_o !== 1'b0) begin
      $display("FAIL tdo_oe: shift %b idle %b required 1 0", oe, tdo_oe_o);
      tests_failed++;
    end
    scan_ir(5'h1f, cap);
    tests_run++;
    if (cap !== 5'b00001) begin
      $display("FAIL ir_capture: got %b required 00001", cap);
      tests_failed++;
    end
    scan_dr(64'h1, 1, dout, oe);
    tests_run++;
    if (dout[0] !== 1'b0) begin
      $display("FAIL bypass_capture: got %b required 0", dout[0]);
      tests_failed++;
    end
  endtask

  task automatic test_dtmcs;
    logic [63:0] dout;
    logic [4:0]  cap;
    logic        oe;
    scan_ir(5'h10, cap);
    scan_dr(64'h0, 32, dout, oe);
    tests_run++;
    if (dout[31:0] !== 32'h00001111) begin
      $display("FAIL dtmcs_read: got %h required 00001111", dout[31:0]);
      tests_failed++;
    end
  endtask

  task automatic test_write_read;
    logic [63:0] dout;
    logic [4:0]  cap;
    logic        oe, v, w, rr;
    logic [16:0] a;
    logic [31:0] d;
    scan_ir(5'h11, cap);
    scan_dr(dmi(17'h3, 32'hfaceb00c, 2'd2), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== 51'h0) begin
      $display("FAIL dmi_first_capture: got %h required 0", dout[50:0]);
      tests_failed++;
    end
    downstream(32'h0, 1'b0, v, w, a, d, rr);
    tests_run++;
    if ({v, w, a, d, rr} !== {1'b1, 1'b1, 17'h3, 32'hfaceb00c, 1'b1}) begin
      $display("FAIL write_req: got v%b w%b a%h d%h rr%b required v1 w1 a00003 dfaceb00c rr1", v, w, a, d, rr);
      tests_failed++;
    end
    scan_dr(dmi(17'h3, 32'h0, 2'd1), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== dmi(17'h3, 32'h0, 2'd0)) begin
      $display("FAIL after_write_capture: got %h required %h", dout[50:0], dmi(17'h3, 32'h0, 2'd0));
      tests_failed++;
    end
    downstream(32'hfaceb00c, 1'b0, v, w, a, d, rr);
    tests_run++;
    if ({v, w, a, rr} !== {1'b1, 1'b0, 17'h3, 1'b1}) begin
      $display("FAIL read_req: got v%b w%b a%h rr%b required v1 w0 a00003 rr1", v, w, a, rr);
      tests_failed++;
    end
    scan_dr(dmi(17'h0, 32'h0, 2'd0), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== dmi(17'h3, 32'hfaceb00c, 2'd0) || req_valid_o !== 1'b0) begin
      $display("FAIL read_capture: got %h valid %b required %h valid 0",
               dout[50:0], req_valid_o, dmi(17'h3, 32'hfaceb00c, 2'd0));
      tests_failed++;
    end
  endtask

  task automatic test_autoinc;
    logic [63:0] dout;
    logic        oe, v, w, rr;
    logic [16:0] a;
    logic [31:0] d;
    scan_dr(dmi(17'h1ffff, 32'h0, 2'd3), 51, dout, oe);
    downstream(32'h12345678, 1'b0, v, w, a, d, rr);
    tests_run++;
    if ({v, w, a} !== {1'b1, 1'b0, 17'h1ffff}) begin
      $display("FAIL autoinc_req: got v%b w%b a%h required v1 w0 a1ffff", v, w, a);
      tests_failed++;
    end
    scan_dr(dmi(17'h0, 32'h0, 2'd0), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== dmi(17'h0, 32'h12345678, 2'd0)) begin
      $display("FAIL autoinc_wrap: got %h required %h", dout[50:0], dmi(17'h0, 32'h12345678, 2'd0));
      tests_failed++;
    end
  endtask

  task automatic test_busy;
    logic [63:0] dout;
    logic [4:0]  cap;
    logic        oe, b;
    scan_dr(dmi(17'h5, 32'ha5, 2'd2), 51, dout, oe);
    tests_run++;
    if ({req_valid_o, req_write_o, req_addr_o} !== {1'b1, 1'b1, 17'h5}) begin
      $display("FAIL busy_first_req: got v%b w%b a%h required v1 w1 a00005", req_valid_o, req_write_o, req_addr_o);
      tests_failed++;
    end
    scan_dr(dmi(17'h6, 32'h0, 2'd1), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== dmi(17'h5, 32'h12345678, 2'd3) || req_addr_o !== 17'h5 || req_write_o !== 1'b1) begin
      $display("FAIL busy_capture: got %h a%h w%b required %h a00005 w1",
               dout[50:0], req_addr_o, req_write_o, dmi(17'h5, 32'h12345678, 2'd3));
      tests_failed++;
    end
    scan_ir(5'h10, cap);
    scan_dr(64'h0, 32, dout, oe);
    tests_run++;
    if (dout[31:0] !== 32'h00001d11) begin
      $display("FAIL busy_sticky: got %h required 00001d11", dout[31:0]);
      tests_failed++;
    end
    scan_dr(64'h1 << 16, 32, dout, oe);
    scan_dr(64'h0, 32, dout, oe);
    tests_run++;
    if (dout[31:0] !== 32'h00001111 || req_valid_o !== 1'b1) begin
      $display("FAIL dmireset: got %h valid %b required 00001111 valid 1", dout[31:0], req_valid_o);
      tests_failed++;
    end
    scan_dr(64'h1 << 17, 32, dout, oe);
    tests_run++;
    if (req_valid_o !== 1'b0) begin
      $display("FAIL hardreset_drop: got valid %b required 0", req_valid_o);
      tests_failed++;
    end
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'hdead0000;
    tck_step(1'b0, 1'b0, b);
    rsp_valid_i = 1'b0;
    scan_ir(5'h11, cap);
    scan_dr(dmi(17'h0, 32'h0, 2'd0), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== dmi(17'h5, 32'h12345678, 2'd0) || rsp_ready_o !== 1'b0) begin
      $display("FAIL stray_rsp_ignored: got %h rr%b required %h rr0",
               dout[50:0], rsp_ready_o, dmi(17'h5, 32'h12345678, 2'd0));
      tests_failed++;
    end
  endtask

  task automatic test_error;
    logic [63:0] dout;
    logic        oe, v, w, rr;
    logic [16:0] a;
    logic [31:0] d;
    scan_dr(dmi(17'h7, 32'h0, 2'd1), 51, dout, oe);
    downstream(32'hbad0bad0, 1'b1, v, w, a, d, rr);
    scan_dr(dmi(17'h8, 32'h0, 2'd1), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== dmi(17'h7, 32'hbad0bad0, 2'd2)) begin
      $display("FAIL err_capture: got %h required %h", dout[50:0], dmi(17'h7, 32'hbad0bad0, 2'd2));
      tests_failed++;
    end
    tests_run++;
    if (req_valid_o !== 1'b0) begin
      $display("FAIL err_suppress: got valid %b required 0", req_valid_o);
      tests_failed++;
    end
    scan_dr(dmi(17'h0, 32'h0, 2'd0), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== dmi(17'h7, 32'hbad0bad0, 2'd2)) begin
      $display("FAIL err_unchanged: got %h required %h", dout[50:0], dmi(17'h7, 32'hbad0bad0, 2'd2));
      tests_failed++;
    end
  endtask

  task automatic test_trst_mid;
    logic [63:0] dout;
    logic [4:0]  cap;
    logic        oe, b;
    scan_ir(5'h10, cap);
    scan_dr(64'h1 << 16, 32, dout, oe);
    scan_ir(5'h11, cap);
    scan_dr(dmi(17'h9, 32'h11111111, 2'd1), 51, dout, oe);
    req_ready_i = 1'b1;
    tck_step(1'b0, 1'b0, b);
    req_ready_i = 1'b0;
    tests_run++;
    if (rsp_ready_o !== 1'b1 || req_addr_o !== 17'h9) begin
      $display("FAIL trst_setup: got rr%b a%h required rr1 a00009", rsp_ready_o, req_addr_o);
      tests_failed++;
    end
    trst_ = 1'b1;
    #1;
    tests_run++;
    if ({td_o, tdo_oe_o, req_valid_o, req_write_o, rsp_ready_o, req_addr_o, req_data_o} !== '0) begin
      $display("FAIL trst_mid_outputs: got %h required 0",
               {td_o, tdo_oe_o, req_valid_o, req_write_o, rsp_ready_o, req_addr_o, req_data_o});
      tests_failed++;
    end
    @(negedge tck_i);
    #1 trst_ = 1'b0;
    tck_step(1'b0, 1'b0, b);
    scan_ir(5'h11, cap);
    scan_dr(dmi(17'h0, 32'h0, 2'd0), 51, dout, oe);
    tests_run++;
    if (dout[50:0] !== 51'h0) begin
      $display("FAIL trst_cleared_state: got %h required 0", dout[50:0]);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset;
    test_dtmcs;
    test_write_read;
    test_autoinc;
    test_busy;
    test_error;
    test_trst_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jtag_dmi_tap.md
# jtag_dmi_tap

Parametrised JTAG TAP and debug-module-interface (DMI) transport running entirely in the `tck` domain. It decodes IDCODE, BYPASS, DTMCS and DMIACCESS, and turns DMIACCESS scans into single request/response transactions toward the existing AXI-lite master CDC. Compared with the first-generation bridge it adds:
- configurable address and data widths,
- sticky busy/error status with `dmireset` and `dmihardreset`,
- an auto-increment read mode for burst reads.

## Interface
Parameters:
- `IR_LENGTH`, 5, instruction register width (must be ≥ 5)
- `AW`, 17, DMI address width (1..63)
- `DW`, 32, DMI data width (8..64)
- `IDCODE_VALUE`, 32'hdeadbeef, IDCODE register contents; bit 0 forced to 1

Ports:
- `tck_i` in 1: JTAG clock
- `trst_` in 1: reset, asynchronous, active-high
- `tms_i` in 1: test mode select, sampled on `tck` rise
- `td_i` in 1: test data in, sampled on `tck` rise
- `td_o` out 1: test data out, driven on `tck` fall
- `tdo_oe_o` out 1: output enable, high in Shift-IR/Shift-DR
- `req_valid_o` out 1: DMI request valid
- `req_ready_i` in 1: downstream accepts request
- `req_write_o` out 1: 1 = write, 0 = read
- `req_addr_o` out AW: request address
- `req_data_o` out DW: write data
- `rsp_valid_i` in 1: response valid
- `rsp_ready_o` out 1: block accepts response
- `rsp_data_i` in DW: read data
- `rsp_err_i` in 1: response carries an error

## Operation
TAP controller:
- Standard 16-state IEEE 1149.1 FSM.
- Test-Logic-Reset is entered on `trst_`, or on 5 consecutive `tms=1`.
- In Test-Logic-Reset: IR=IDCODE, sticky status cleared, outstanding transaction abandoned.

IR codes:
- 5'h01 IDCODE
- 5'h10 DTMCS
- 5'h11 DMIACCESS
- 5'h00 and 5'h1f BYPASS
- Any other code selects BYPASS.
- Capture-IR loads 5'b00001.

DTMCS (32 bits), read fields:
- [3:0] version = 1
- [9:4] abits = AW
- [11:10] dmistat
- [14:12] idle = 1

DTMCS, write fields (applied on Update-DR):
- [16] `dmireset`: clears sticky status.
- [17] `dmihardreset`: clears sticky status, drops `req_valid_o`, returns the engine to IDLE and discards any later response.

DMIACCESS (AW+DW+2 bits, LSB first):
- Layout {addr, data, op}.
- Capture-DR loads {last_addr, last_rdata, dmistat}.
- dmistat: 0 = ok, 2 = failed, 3 = busy.

Op field on Update-DR:
- 0: nop
- 1: read
- 2: write
- 3: read, then post-increment the stored address.

Engine FSM, states IDLE, REQ, RSP:
- IDLE → REQ on Update-DR of DMIACCESS with op≠0 and dmistat==0. Latches addr, data and write.
- REQ → RSP on `req_valid_o && req_ready_i`.
- RSP → IDLE on `rsp_valid_i && rsp_ready_o`:
  - Latches `rsp_data_i` for reads only.
  - `rsp_err_i` sets sticky dmistat=2.
  - op 3 sets last_addr = addr+1, wrapping modulo 2^AW.

Boundary rules:
- Update-DR with op≠0 while in REQ or RSP: request dropped, sticky dmistat=3.
- Any Capture-DR of DMIACCESS while in REQ or RSP returns dmistat=3, without making it sticky.
- Update-DR while dmistat≠0: request ignored, status unchanged.
- Update-DR with op=0: no request, no status change.

## Timing
Reset values:
- `td_o`=0, `tdo_oe_o`=0
- `req_valid_o`=0, `req_write_o`=0, `req_addr_o`=0, `req_data_o`=0
- `rsp_ready_o`=0
- last_addr and last_rdata = 0, dmistat = 0
- TAP in Test-Logic-Reset, IR=IDCODE

Request/response handshake:
- `req_valid_o` rises on the `tck` rising edge that leaves Update-DR.
- Request payload is stable while `req_valid_o` is high.
- `req_valid_o` falls on the edge after the handshake.
- `rsp_ready_o` is high exactly in RSP.
- A response accepted on edge N is visible at the next Capture-DR after N.
- An asserted `rsp_valid_i` outside RSP is ignored.

Data path:
- `td_o` is updated on `tck` falling edges and carries DR/IR bit 0 during shift.
- `tdo_oe_o` tracks Shift-IR/Shift-DR, updated on falling edges.

Other timing:
- `trst_` asserted mid-transaction clears `req_valid_o` immediately (asynchronously).
- Minimum turnaround with a zero-wait-state downstream: request edge + 1 (ready) + 1 (response).

## Structure
- Package `jtag_dmi_pkg` holds:
  - IR code localparams
  - `tap_state_e` (16 states)
  - `dmi_op_e`, `dmi_stat_e`
  - DTMCS field offsets
- Sub-module `jtag_tap_fsm` contains the TAP state register and next-state logic, and outputs one-hot capture/shift/update strobes for IR and DR.
- The top holds IR, DR shift registers and the engine FSM.

## Test plan
- `trst_` pulse, then 32-bit DR scan with default IR → `td_o` stream = 32'hdeadbeef, LSB first.
- IR=DTMCS capture → bits [9:4]=17, [3:0]=1, dmistat=0.
- DMIACCESS write {17'h3, 32'hfaceb00c, 2}, then read {3, x, 1}, then nop → request write@3, then read@3 (bench returns 32'hfaceb00c); final capture = {3, 32'hfaceb00c, 0}.
- Op 3 at 17'h1ffff → read issued at 17'h1ffff; next capture shows addr 0.
- `req_ready_i` held low, second DMIACCESS update → capture dmistat=3, no second request; DTMCS `dmireset` → dmistat=0.
- `rsp_err_i`=1 on a read → dmistat=2, next requests suppressed. `dmihardreset` during REQ → `req_valid_o`=0 next edge. `trst_` mid-RSP → all outputs at reset values.
